// File: rtl/lfsr_checker.sv
// Receive-side checker for the 4-bit LFSR pattern generator: locks onto the
// serial stream, predicts each following bit and counts mismatches.
module lfsr_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned TAP_HI     = 3,
  parameter int unsigned TAP_LO     = 1,
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned LOAD_W   = $clog2(WIDTH + 1);
  localparam int unsigned CONSEC_W = 4;

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hist_q, hist_d;
  logic [LOAD_W-1:0]  load_cnt_q, load_cnt_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pred_c;
  logic               mismatch_c;
  logic               load_last_c;
  logic               thresh_hit_c;
  logic [WIDTH-1:0]   hunt_hist_c;
  logic [WIDTH-1:0]   check_hist_c;
  logic [CONSEC_W-1:0] consec_inc_c;

  assign pred_c       = hist_q[TAP_HI] ^ hist_q[TAP_LO];
  assign mismatch_c   = bit_i != pred_c;
  assign hunt_hist_c  = {hist_q[WIDTH-2:0], bit_i};
  // Shift in the prediction so a single flipped bit yields a single error.
  assign check_hist_c = {hist_q[WIDTH-2:0], pred_c};
  assign load_last_c  = load_cnt_q == LOAD_W'(WIDTH - 1);
  assign consec_inc_c = consec_q + CONSEC_W'(1);
  assign thresh_hit_c = mismatch_c && (consec_inc_c == CONSEC_W'(ERR_THRESH));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bit_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (load_last_c && (hunt_hist_c != '0)) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (thresh_hit_c) begin
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    hist_d     = hist_q;
    load_cnt_d = load_cnt_q;
    consec_d   = consec_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    locked_d   = state_d == CHECK;
    if (bit_valid_i) begin
      unique case (state_q)
        HUNT: begin
          hist_d     = hunt_hist_c;
          load_cnt_d = load_last_c ? '0 : load_cnt_q + LOAD_W'(1);
          consec_d   = '0;
        end
        CHECK: begin
          hist_d = check_hist_c;
          if (mismatch_c) begin
            err_d    = 1'b1;
            consec_d = thresh_hit_c ? '0 : consec_inc_c;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (thresh_hit_c) begin
              load_cnt_d = '0;
            end
          end else begin
            consec_d = '0;
          end
        end
        default: ;
      endcase
    end
    if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q     <= '0;
      load_cnt_q <= '0;
      consec_q   <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      hist_q     <= hist_d;
      load_cnt_q <= load_cnt_d;
      consec_q   <= consec_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

endmodule
